// File: rtl/comparator_pkg.sv
// Shared types and helpers for the registered three-way magnitude comparator.
package comparator_pkg;

    typedef enum logic [1:0] {
        CMP_LT = 2'd0,
        CMP_EQ = 2'd1,
        CMP_GT = 2'd2
    } cmp_result_t;

    // Decode a compare result into {greater, equal, lesser}; the unused
    // encoding maps to all-zero so it can never look like a valid one-hot.
    function automatic logic [2:0] to_flags(input cmp_result_t r);
        logic [2:0] flags;
        case (r)
            CMP_GT:  flags = 3'b100;
            CMP_EQ:  flags = 3'b010;
            CMP_LT:  flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/comparator_core.sv
// Purely combinational MSB-first compare cascade. In signed mode both sign
// bits are inverted so the two's-complement ordering becomes an unsigned one.
module comparator_core
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_result_t      result
);

    localparam logic [WIDTH-1:0] SIGN_MASK =
        (SIGNED_CMP != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    logic [WIDTH-1:0] a_biased;
    logic [WIDTH-1:0] b_biased;
    logic             decided;

    assign a_biased = a ^ SIGN_MASK;
    assign b_biased = b ^ SIGN_MASK;

    // Walk from the MSB down; the first differing bit decides the order,
    // and if no bit differs the operands are equal.
    always_comb begin
        result  = CMP_EQ;
        decided = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!decided && (a_biased[i] != b_biased[i])) begin
                decided = 1'b1;
                result  = a_biased[i] ? CMP_GT : CMP_LT;
            end
        end
    end

endmodule

// File: rtl/comparator.sv
// Registered three-way comparator: one-cycle latency, one compare per clock,
// flags hold their last value while out_valid is low.
module comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int SIGNED_CMP = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    output logic             greater,
    output logic             equal,
    output logic             lesser
);

    cmp_result_t cmp_res;

    comparator_core #(
        .WIDTH      (WIDTH),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_core (
        .a      (A),
        .b      (B),
        .result (cmp_res)
    );

    // Register the decoded flags only on valid cycles so they hold otherwise;
    // reset clears everything and wins over an incoming compare.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            greater   <= 1'b0;
            equal     <= 1'b0;
            lesser    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                {greater, equal, lesser} <= to_flags(cmp_res);
            end
        end
    end

endmodule

// File: tb/tb_comparator.sv
// Scoreboard bench for comparator: an unsigned and a signed instance share
// the same stimulus; expected flags are queued at issue time and popped by
// an independent monitor whenever an instance raises out_valid.
module tb_comparator;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] EQ = 3'b010;
    localparam logic [2:0] LT = 3'b001;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       inValid = 1'b0;
    logic [3:0] aIn = 4'h0;
    logic [3:0] bIn = 4'h0;

    logic uVld, uGt, uEq, uLt;
    logic sVld, sGt, sEq, sLt;

    logic [2:0] qU[$];
    logic [2:0] qS[$];
    logic       pendingValid = 1'b0;
    logic       pendingReset = 1'b1;
    logic [2:0] heldU = 3'b000;
    logic [2:0] heldS = 3'b000;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    comparator #(.WIDTH(4), .SIGNED_CMP(0)) dutU (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .A         (aIn),
        .B         (bIn),
        .out_valid (uVld),
        .greater   (uGt),
        .equal     (uEq),
        .lesser    (uLt)
    );

    comparator #(.WIDTH(4), .SIGNED_CMP(1)) dutS (
        .clk       (clk),
        .rst_n     (rstN),
        .in_valid  (inValid),
        .A         (aIn),
        .B         (bIn),
        .out_valid (sVld),
        .greater   (sGt),
        .equal     (sEq),
        .lesser    (sLt)
    );

    // Independent reference: language-level compares, not a bit cascade.
    function automatic logic [2:0] refFlags(input logic [3:0] a, input logic [3:0] b, input bit sgn);
        if (sgn) begin
            if ($signed(a) > $signed(b)) return GT;
            if ($signed(a) < $signed(b)) return LT;
            return EQ;
        end
        if (a > b) return GT;
        if (a < b) return LT;
        return EQ;
    endfunction

    task automatic checkOutput(input string name, input logic [2:0] act, input logic [2:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what each
    // instance must report one rising edge later.
    task automatic applyStimulus(input logic rst, input logic vld, input logic [3:0] a,
                                 input logic [3:0] b, input logic [2:0] expU, input logic [2:0] expS);
        @(negedge clk);
        rstN         = rst;
        inValid      = vld;
        aIn          = a;
        bIn          = b;
        pendingValid = rst && vld;
        pendingReset = !rst;
        if (rst && vld) begin
            qU.push_back(expU);
            qS.push_back(expS);
        end
    endtask

    // Monitor: just after each rising edge, compare valid against the
    // expected qualifier, pop on valid, otherwise require the held flags.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (pendingReset) begin
                heldU = 3'b000;
                heldS = 3'b000;
            end
            checkOutput("u_valid", {2'b00, uVld}, {2'b00, pendingValid});
            checkOutput("s_valid", {2'b00, sVld}, {2'b00, pendingValid});
            if (uVld === 1'b1) begin
                if (qU.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL u_unexpected at %0t: got out_valid=1 expected no output", $time);
                end else begin
                    e = qU.pop_front();
                    checkOutput("u_flags", {uGt, uEq, uLt}, e);
                    heldU = e;
                end
            end else begin
                checkOutput("u_hold", {uGt, uEq, uLt}, heldU);
            end
            if (sVld === 1'b1) begin
                if (qS.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL s_unexpected at %0t: got out_valid=1 expected no output", $time);
                end else begin
                    e = qS.pop_front();
                    checkOutput("s_flags", {sGt, sEq, sLt}, e);
                    heldS = e;
                end
            end else begin
                checkOutput("s_hold", {sGt, sEq, sLt}, heldS);
            end
        end
    end

    // Directed vectors, valid gating, then a random run with one reset.
    initial begin
        int resetCycle;
        logic [3:0] ra, rb;

        // Reset held for two cycles with a live compare on the inputs.
        applyStimulus(1'b0, 1'b1, 4'h5, 4'h3, GT, GT);
        applyStimulus(1'b0, 1'b1, 4'h5, 4'h3, GT, GT);

        // Directed: {A, B, unsigned expectation, signed expectation}.
        applyStimulus(1'b1, 1'b1, 4'h9, 4'h3, GT, LT);
        applyStimulus(1'b1, 1'b1, 4'h3, 4'hD, LT, GT);
        applyStimulus(1'b1, 1'b1, 4'hD, 4'hD, EQ, EQ);
        applyStimulus(1'b1, 1'b1, 4'h0, 4'h0, EQ, EQ);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'hF, EQ, EQ);
        applyStimulus(1'b1, 1'b1, 4'h0, 4'hF, LT, GT);
        applyStimulus(1'b1, 1'b1, 4'hF, 4'h0, GT, LT);
        applyStimulus(1'b1, 1'b1, 4'h8, 4'h0, GT, LT);
        applyStimulus(1'b1, 1'b1, 4'h8, 4'h7, GT, LT);
        applyStimulus(1'b1, 1'b1, 4'h1, 4'hF, LT, GT);
        applyStimulus(1'b1, 1'b1, 4'h4, 4'h5, LT, LT);
        applyStimulus(1'b1, 1'b1, 4'h5, 4'h4, GT, GT);

        // Valid gating: one valid cycle, then idle; flags must hold GT.
        applyStimulus(1'b1, 1'b1, 4'h2, 4'h1, GT, GT);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, LT, GT);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, LT, GT);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, LT, GT);

        // Random back-to-back run with a single reset cycle inside it.
        resetCycle = $urandom_range(100, 900);
        for (int i = 0; i < 1000; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            applyStimulus((i == resetCycle) ? 1'b0 : 1'b1, 1'b1, ra, rb,
                          refFlags(ra, rb, 1'b0), refFlags(ra, rb, 1'b1));
        end

        // Drain and confirm every queued result was emitted.
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, EQ, EQ);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, EQ, EQ);
        applyStimulus(1'b1, 1'b0, 4'h0, 4'h0, EQ, EQ);
        @(posedge clk);
        #2;
        compared++;
        if (qU.size() != 0 || qS.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: got %0d/%0d results left expected 0/0", qU.size(), qS.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
